// File: rtl/game_monitor_pkg.sv
// Shared encodings and field positions for the game monitor slice.
package game_monitor_pkg;

    // Monitor phase as seen on the phase output.
    typedef enum logic [1:0] {
        PH_IDLE = 2'b00,
        PH_RUN  = 2'b01,
        PH_OVER = 2'b10
    } phase_t;

    // Game controller status encodings.
    localparam logic [1:0] ST_SINGLE = 2'b00;
    localparam logic [1:0] ST_INIT_A = 2'b01;
    localparam logic [1:0] ST_INIT_B = 2'b10;
    localparam logic [1:0] ST_DUAL   = 2'b11;

    // Pipe word fields: [27:20] gap, [19:10] x, [9:0] y.
    localparam int PIPE_GAP_MSB = 27;
    localparam int PIPE_GAP_LSB = 20;
    localparam int PIPE_X_MSB   = 19;
    localparam int PIPE_X_LSB   = 10;
    localparam int PIPE_Y_MSB   = 9;
    localparam int PIPE_Y_LSB   = 0;

    // Coin word fields: [31] valid, [19:10] y, [9:0] x.
    localparam int COIN_V_BIT   = 31;
    localparam int COIN_Y_MSB   = 19;
    localparam int COIN_Y_LSB   = 10;
    localparam int COIN_X_MSB   = 9;
    localparam int COIN_X_LSB   = 0;

    // Bird height field and playfield limit.
    localparam int BIRD_H_MSB   = 14;
    localparam logic [14:0] PLAY_HEIGHT = 15'd480;

endpackage

// File: rtl/game_monitor_if.sv
// Bus bundle between the game controller (master) and the monitor (slave).
interface game_monitor_if;
    import game_monitor_pkg::*;

    logic        hs_clr;
    logic [1:0]  status;
    logic [15:0] score;
    logic [15:0] bird_y;
    logic [31:0] pipe1;
    logic [31:0] pipe2;
    logic [31:0] pipe3;
    logic [31:0] coin;

    logic [1:0]  phase;
    logic        dual;
    logic [15:0] high_score;
    logic        new_record;
    logic [2:0]  respawn;
    logic        coin_taken;
    logic        score_flash;
    logic        bird_lost;
    logic [15:0] run_ticks;

    modport master (
        output hs_clr, status, score, bird_y, pipe1, pipe2, pipe3, coin,
        input  phase, dual, high_score, new_record, respawn, coin_taken,
               score_flash, bird_lost, run_ticks
    );

    modport slave (
        input  hs_clr, status, score, bird_y, pipe1, pipe2, pipe3, coin,
        output phase, dual, high_score, new_record, respawn, coin_taken,
               score_flash, bird_lost, run_ticks
    );

endinterface

// File: rtl/game_monitor_pipe_tracker.sv
// Tracks one pipe's x position: keeps last tick's x, flags a respawn
// (x jumped forward) and reports whether x stood still this tick.
module pipe_tracker
    import game_monitor_pkg::*;
(
    input  logic        clk_100ms,
    input  logic        rst,
    input  logic [9:0]  x_cur,
    input  logic        en,
    output logic [9:0]  x_prev,
    output logic        respawn,
    output logic        stall
);

    // Pipe x normally decreases; equality means the game has frozen.
    assign stall = (x_cur == x_prev);

    // History register and one-tick respawn pulse, gated by the run phase.
    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            x_prev  <= '0;
            respawn <= 1'b0;
        end else begin
            x_prev  <= x_cur;
            respawn <= en && (x_cur > x_prev);
        end
    end

endmodule

// File: rtl/game_monitor.sv
// Game monitor: follows the game phase from the controller's bus, detects
// stalls, respawns, coin pickups and score records.
module game_monitor
    import game_monitor_pkg::*;
#(
    parameter int STALL_TICKS = 3,
    parameter int FLASH_TICKS = 10
) (
    input  logic          clk_100ms,
    input  logic          rst,
    game_monitor_if.slave bus
);

    localparam int SW = $clog2(STALL_TICKS + 1);
    localparam int FW = $clog2(FLASH_TICKS + 1);

    phase_t        phase_q;
    logic          dual_q;
    logic          new_record_q;
    logic          coin_taken_q;
    logic [15:0]   run_ticks_q;
    logic [SW-1:0] stall_cnt;
    logic [FW-1:0] flash_cnt;
    logic [15:0]   score_q;
    logic          coin_v_q;
    logic [15:0]   high_score_q = '0;

    logic [2:0]    resp;
    logic [2:0]    stall;
    logic [9:0]    x_hist [3];
    logic          in_run;
    logic          record;

    assign in_run = (phase_q == PH_RUN);
    assign record = in_run && (bus.score > high_score_q);

    pipe_tracker u_pipe1 (.clk_100ms(clk_100ms), .rst(rst),
        .x_cur(bus.pipe1[PIPE_X_MSB:PIPE_X_LSB]), .en(in_run),
        .x_prev(x_hist[0]), .respawn(resp[0]), .stall(stall[0]));
    pipe_tracker u_pipe2 (.clk_100ms(clk_100ms), .rst(rst),
        .x_cur(bus.pipe2[PIPE_X_MSB:PIPE_X_LSB]), .en(in_run),
        .x_prev(x_hist[1]), .respawn(resp[1]), .stall(stall[1]));
    pipe_tracker u_pipe3 (.clk_100ms(clk_100ms), .rst(rst),
        .x_cur(bus.pipe3[PIPE_X_MSB:PIPE_X_LSB]), .en(in_run),
        .x_prev(x_hist[2]), .respawn(resp[2]), .stall(stall[2]));

    // Phase FSM together with its registered status outputs and counters.
    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            phase_q      <= PH_IDLE;
            dual_q       <= 1'b0;
            new_record_q <= 1'b0;
            coin_taken_q <= 1'b0;
            run_ticks_q  <= '0;
            stall_cnt    <= '0;
            flash_cnt    <= '0;
            score_q      <= '0;
            coin_v_q     <= 1'b0;
        end else begin
            score_q      <= bus.score;
            coin_v_q     <= bus.coin[COIN_V_BIT];
            // Only a valid-to-invalid edge is a pickup; the reverse is a respawn.
            coin_taken_q <= in_run && coin_v_q && !bus.coin[COIN_V_BIT];

            // A fresh increase restarts the window from the full length.
            if (in_run && (bus.score > score_q))
                flash_cnt <= FW'(FLASH_TICKS);
            else if (flash_cnt != '0)
                flash_cnt <= flash_cnt - 1'b1;

            // A same-tick high-score clear suppresses the record flag.
            if (record && !bus.hs_clr)
                new_record_q <= 1'b1;

            case (phase_q)
                PH_IDLE: begin
                    stall_cnt <= '0;
                    if (bus.status == ST_SINGLE || bus.status == ST_DUAL) begin
                        phase_q <= PH_RUN;
                        dual_q  <= (bus.status == ST_DUAL);
                    end
                end
                PH_RUN: begin
                    if (run_ticks_q != 16'hFFFF)
                        run_ticks_q <= run_ticks_q + 16'd1;
                    if (stall[0]) begin
                        if (stall_cnt == SW'(STALL_TICKS - 1)) begin
                            phase_q   <= PH_OVER;
                            stall_cnt <= '0;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end else begin
                        stall_cnt <= '0;
                    end
                end
                PH_OVER: begin
                    stall_cnt <= '0;
                end
                default: begin
                    phase_q   <= PH_IDLE;
                    stall_cnt <= '0;
                end
            endcase
        end
    end

    // High score survives reset; only the explicit clear zeroes it.
    always_ff @(posedge clk_100ms) begin
        if (bus.hs_clr)
            high_score_q <= '0;
        else if (record)
            high_score_q <= bus.score;
    end

    assign bus.phase       = phase_q;
    assign bus.dual        = dual_q;
    assign bus.high_score  = high_score_q;
    assign bus.new_record  = new_record_q;
    assign bus.respawn     = resp;
    assign bus.coin_taken  = coin_taken_q;
    assign bus.score_flash = (flash_cnt != '0);
    assign bus.run_ticks   = run_ticks_q;
    // Above the playfield or wrapped below zero both read as > PLAY_HEIGHT.
    assign bus.bird_lost   = (bus.bird_y[BIRD_H_MSB:0] > PLAY_HEIGHT);

endmodule

// File: tb/tb_game_monitor.sv
// Directed bench for game_monitor: phase flow, pulses, records, bird bounds.
module tb_game_monitor;
    import game_monitor_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    int   exp_rt = 0;
    bit   exp_run = 1'b0;
    bit   p1_move = 1'b0;
    logic [9:0] p1x = 10'd0;

    game_monitor_if bus ();

    game_monitor #(.STALL_TICKS(3), .FLASH_TICKS(10)) dut (
        .clk_100ms(clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pw(input logic [9:0] x);
        return {4'd0, 8'd0, x, 10'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Drive pipe1 motion, advance one tick, sample 1 time unit after the edge.
    task automatic tick();
        if (p1_move) begin
            p1x = p1x - 10'd2;
            bus.pipe1 = pw(p1x);
        end
        if (exp_run) exp_rt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        bus.hs_clr = 1'b0;
        bus.status = ST_INIT_A;
        bus.score  = 16'd0;
        bus.bird_y = 16'd0;
        bus.pipe1  = 32'd0;
        bus.pipe2  = 32'd0;
        bus.pipe3  = 32'd0;
        bus.coin   = 32'd0;
        tick();
        tick();

        // Reset state
        chk("rst_phase", 32'(bus.phase), 32'(PH_IDLE));
        chk("rst_dual", 32'(bus.dual), 0);
        chk("rst_new_record", 32'(bus.new_record), 0);
        chk("rst_respawn", 32'(bus.respawn), 0);
        chk("rst_coin_taken", 32'(bus.coin_taken), 0);
        chk("rst_flash", 32'(bus.score_flash), 0);
        chk("rst_run_ticks", 32'(bus.run_ticks), 0);
        chk("cfg_high_score", 32'(bus.high_score), 0);

        // Bird bounds
        bus.bird_y = 16'h7FF6; #1;
        chk("bird_wrap", 32'(bus.bird_lost), 1);
        bus.bird_y = 16'd240; #1;
        chk("bird_mid", 32'(bus.bird_lost), 0);
        bus.bird_y = 16'd480; #1;
        chk("bird_480", 32'(bus.bird_lost), 0);
        bus.bird_y = 16'h81E1; #1;
        chk("bird_481_rising", 32'(bus.bird_lost), 1);
        bus.bird_y = 16'd100;

        // Start single run, pipe1 x 210, 208, 206
        rst = 1'b1;
        bus.status = ST_SINGLE;
        p1x = 10'd212;
        p1_move = 1'b1;
        tick();
        chk("start_phase", 32'(bus.phase), 32'(PH_RUN));
        chk("start_dual", 32'(bus.dual), 0);
        chk("start_run_ticks", 32'(bus.run_ticks), 0);
        exp_run = 1'b1;
        tick();
        tick();
        chk("run_ticks_2", 32'(bus.run_ticks), 2);
        chk("no_respawn_decr", 32'(bus.respawn), 0);

        // Pipe2 respawn 0 -> 640
        bus.pipe2 = pw(10'd640);
        tick();
        chk("respawn_pulse", 32'(bus.respawn), 32'h2);
        tick();
        chk("respawn_end", 32'(bus.respawn), 0);

        // Coin: respawn edge, pickup edge, respawn edge
        bus.coin = 32'h8000_1234;
        tick();
        chk("coin_rise_none", 32'(bus.coin_taken), 0);
        bus.coin = 32'h0000_1234;
        tick();
        chk("coin_taken", 32'(bus.coin_taken), 1);
        tick();
        chk("coin_taken_end", 32'(bus.coin_taken), 0);
        bus.coin = 32'h8000_1234;
        tick();
        chk("coin_rise_none2", 32'(bus.coin_taken), 0);

        // hs_clr wins over a same-tick record
        bus.score = 16'd3;
        bus.hs_clr = 1'b1;
        tick();
        chk("clr_hs", 32'(bus.high_score), 0);
        chk("clr_no_record", 32'(bus.new_record), 0);
        chk("clr_flash", 32'(bus.score_flash), 1);
        bus.hs_clr = 1'b0;
        tick();
        chk("later_hs", 32'(bus.high_score), 3);
        chk("later_record", 32'(bus.new_record), 1);
        bus.score = 16'd5;
        tick();
        chk("hs_5", 32'(bus.high_score), 5);

        // Mid-run asynchronous reset
        rst = 1'b0;
        #1;
        exp_run = 1'b0;
        exp_rt = 0;
        chk("mid_rst_phase", 32'(bus.phase), 32'(PH_IDLE));
        chk("mid_rst_record", 32'(bus.new_record), 0);
        chk("mid_rst_run_ticks", 32'(bus.run_ticks), 0);
        chk("mid_rst_flash", 32'(bus.score_flash), 0);
        chk("mid_rst_hs_kept", 32'(bus.high_score), 5);

        // Dual run; no pulses on first tick after release
        rst = 1'b1;
        bus.status = ST_DUAL;
        tick();
        chk("dual_phase", 32'(bus.phase), 32'(PH_RUN));
        chk("dual_latched", 32'(bus.dual), 1);
        chk("post_rst_respawn", 32'(bus.respawn), 0);
        chk("post_rst_coin", 32'(bus.coin_taken), 0);
        chk("post_rst_flash", 32'(bus.score_flash), 0);
        exp_run = 1'b1;
        tick();
        bus.score = 16'd6;
        tick();
        chk("rec_hs_6", 32'(bus.high_score), 6);
        chk("rec_new_record", 32'(bus.new_record), 1);
        chk("rec_flash_on", 32'(bus.score_flash), 1);
        for (int i = 0; i < 9; i++) tick();
        chk("flash_tick_10", 32'(bus.score_flash), 1);
        tick();
        chk("flash_off", 32'(bus.score_flash), 0);

        // Reset keeps high score
        rst = 1'b0;
        #1;
        exp_run = 1'b0;
        exp_rt = 0;
        chk("rst_hs_kept_6", 32'(bus.high_score), 6);
        rst = 1'b1;
        bus.status = ST_SINGLE;
        tick();
        chk("single_again_dual", 32'(bus.dual), 0);
        exp_run = 1'b1;
        tick();

        // Flash reload, not extend
        bus.score = 16'd7;
        tick();
        tick();
        tick();
        tick();
        bus.score = 16'd8;
        tick();
        for (int i = 0; i < 9; i++) tick();
        chk("reload_flash_on", 32'(bus.score_flash), 1);
        tick();
        chk("reload_flash_off", 32'(bus.score_flash), 0);

        // Stall: pipe1 held for three ticks
        p1_move = 1'b0;
        tick();
        chk("stall_1", 32'(bus.phase), 32'(PH_RUN));
        tick();
        chk("stall_2", 32'(bus.phase), 32'(PH_RUN));
        tick();
        exp_run = 1'b0;
        chk("stall_over", 32'(bus.phase), 32'(PH_OVER));
        chk("over_run_ticks", 32'(bus.run_ticks), 32'(exp_rt));

        // OVER is sticky; movement and respawns ignored
        p1_move = 1'b1;
        bus.pipe3 = pw(10'd500);
        tick();
        chk("over_no_respawn", 32'(bus.respawn), 0);
        tick();
        tick();
        chk("over_sticky", 32'(bus.phase), 32'(PH_OVER));
        chk("over_frozen", 32'(bus.run_ticks), 32'(exp_rt));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/game_monitor.md
GAME_MONITOR -- requirements
Module: game_monitor

Interface
REQ-001 Parameter STALL_TICKS, default 3: consecutive ticks with unchanged pipe x that declare game over.
REQ-002 Parameter FLASH_TICKS, default 10: length of the score-change flash window, in ticks.
REQ-003 clk_100ms  input  1  game tick clock.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 hs_clr  input  1  synchronous clear of the high score.
REQ-006 status  input  2  game controller status (01/10 = init, 00 = single run, 11 = dual run).
REQ-007 score  input  16  current score.
REQ-008 bird_y  input  16  bird word: [15] rising flag, [14:0] height.
REQ-009 pipe1, pipe2, pipe3  input  32 each  pipe words: [31:28] zero, [27:20] gap, [19:10] x, [9:0] y.
REQ-010 coin  input  32  coin word: [31] valid, [19:10] y, [9:0] x.
REQ-011 phase  output  2  monitor state: 00 IDLE, 01 RUN, 10 OVER.
REQ-012 dual  output  1  dual-player run latched.
REQ-013 high_score  output  16  best score seen.
REQ-014 new_record  output  1  current run has beaten high_score.
REQ-015 respawn  output  3  one-tick pulse per pipe on respawn.
REQ-016 coin_taken  output  1  one-tick pulse on coin collection.
REQ-017 score_flash  output  1  high while the flash window is active.
REQ-018 bird_lost  output  1  bird height out of the playfield.
REQ-019 run_ticks  output  16  ticks spent in RUN, saturating.

Function
REQ-020 All inputs shall be sampled on the rising edge of clk_100ms; the block shall keep a one-tick history register of score, coin[31] and the x field of each pipe.
REQ-021 FSM, IDLE to RUN: on status 00 or 11; dual shall be set to (status==11) at that transition.
REQ-022 FSM, RUN to OVER: when the pipe1 x field equals its previous value for STALL_TICKS consecutive ticks; the stall counter shall clear on any change.
REQ-023 FSM, OVER: exited only by rst; in IDLE and OVER the stall counter shall hold at 0.
REQ-024 respawn[n] shall pulse for exactly one tick, the tick after pipe n's x field exceeds its previous value; it shall be active only in RUN.
REQ-025 coin_taken shall pulse for one tick after coin[31] goes 1 to 0 in RUN; a 0-to-1 transition (coin respawn) shall produce no pulse.
REQ-026 Any score increase in RUN shall load the flash counter with FLASH_TICKS; score_flash = (counter != 0); the counter shall decrement once per tick; a new increase shall reload it, not extend it.
REQ-027 In RUN, if score > high_score, high_score shall take score on the next tick and new_record shall be set; new_record shall stay set until rst.
REQ-028 If hs_clr and a record update occur on the same tick, hs_clr shall win: high_score becomes 0 and new_record is set only on a later update.
REQ-029 bird_lost shall be combinational: 1 when bird_y[14:0] > 480 (this also catches underflow wrap).
REQ-030 run_ticks shall increment every tick in RUN, saturate at 0xFFFF, and hold in OVER.
REQ-031 Unsigned comparisons only; the x fields are compared at 10 bits, with no sign interpretation.

Reset
REQ-032 On rst low: phase=IDLE, dual=0, new_record=0, respawn=000, coin_taken=0, score_flash=0, run_ticks=0, flash and stall counters = 0.
REQ-033 On rst low: history registers shall be cleared to 0.
REQ-034 high_score shall NOT be affected by rst; it is cleared only by hs_clr and initialized to 0 at configuration.
REQ-035 Reset asserted mid-RUN shall return to IDLE within the same asynchronous assertion, and no pulse outputs shall fire on the first tick after release.

Structure
REQ-036 A shared package shall hold the phase encodings, the status encodings, the pipe/coin field bit positions and PLAY_HEIGHT=480.
REQ-037 One sub-module, pipe_tracker, shall be instantiated three times: it takes a pipe word and returns the x-field history, the respawn pulse and the stall indication.

Verification
REQ-038 Release rst, status=00, pipe1 x 210,208,206 -> phase RUN on tick 1, dual=0, run_ticks=2 after two further ticks.
REQ-039 In RUN, pipe1 x held at 150 for 3 ticks -> phase OVER on the 3rd tick; run_ticks frozen; further x changes are ignored.
REQ-040 pipe2 x 0 then 640 -> respawn=010 for exactly one tick.
REQ-041 coin 0x8000xxxx then 0x0000xxxx -> one coin_taken pulse; reverse transition -> no pulse.
REQ-042 high_score=5, score steps 5 then 6 -> high_score=6, new_record=1, score_flash high for 10 ticks; rst -> high_score stays 6.
REQ-043 bird_y=16'h7FF6 (wrapped) -> bird_lost=1; bird_y=240 -> bird_lost=0.
